// File: rtl/fft_bin_reader_pkg.sv
`default_nettype none
//==============================================================================
// fft_bin_reader_pkg: shared FFT geometry and reader FSM state encodings.
// Rev 1.0
//==============================================================================
package fft_bin_reader_pkg;

    localparam int FFT_N        = 512;
    localparam int FFT_ADDR_W   = 9;
    localparam int FFT_DATA_W   = 24;
    localparam int FFT_RD_LAT   = 2;
    localparam int FFT_NUM_BINS = FFT_N / 2;

    localparam int         STATE_W = 3;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_MAG   = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fft_bin_reader_if.sv
`default_nettype none
//==============================================================================
// fft_bin_reader_if: valid/ready stream carrying one bin index and |X|^2.
// Rev 1.0
//==============================================================================
interface fft_bin_reader_if
    import fft_bin_reader_pkg::*;
#(
    parameter int ADDR_W = FFT_ADDR_W,
    parameter int DATA_W = FFT_DATA_W
);
    logic                  m_valid;
    logic                  m_ready;
    logic [ADDR_W-1:0]     m_bin;
    logic [2*DATA_W-1:0]   m_mag_sq;
    logic                  m_last;

    modport master (output m_valid, m_bin, m_mag_sq, m_last, input m_ready);
    modport slave  (input m_valid, m_bin, m_mag_sq, m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/fft_bin_reader_mag_sq.sv
`default_nettype none
//==============================================================================
// fft_bin_reader_mag_sq: registered signed re^2 + im^2, one-cycle latency, enable.
// Rev 1.0
//==============================================================================
module fft_bin_reader_mag_sq
    import fft_bin_reader_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_re,
    input  logic signed [DATA_W-1:0] i_im,
    output logic [2*DATA_W-1:0]      o_mag_sq
);
    logic signed [2*DATA_W-1:0] w_re_x;
    logic signed [2*DATA_W-1:0] w_im_x;
    logic signed [2*DATA_W-1:0] w_re2;
    logic signed [2*DATA_W-1:0] w_im2;
    logic [2*DATA_W-1:0]        r_mag_sq;

    // Full-width signed squares; the sum of two can reach 2^47, read as unsigned.
    assign w_re_x = {{DATA_W{i_re[DATA_W-1]}}, i_re};
    assign w_im_x = {{DATA_W{i_im[DATA_W-1]}}, i_im};
    assign w_re2  = w_re_x * w_re_x;
    assign w_im2  = w_im_x * w_im_x;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mag_sq <= '0;
        end else if (i_en) begin
            r_mag_sq <= w_re2 + w_im2;
        end
    end

    assign o_mag_sq = r_mag_sq;
endmodule
`default_nettype wire

// File: rtl/fft_bin_reader.sv
`default_nettype none
//==============================================================================
// fft_bin_reader: sweeps FFT bins after each done edge, streams |X|^2 per bin.
// Optional running peak search enabled by defining FFT_READER_PEAK_EN.
// Rev 1.0
//==============================================================================
module fft_bin_reader
    import fft_bin_reader_pkg::*;
#(
    parameter int ADDR_W   = FFT_ADDR_W,
    parameter int DATA_W   = FFT_DATA_W,
    parameter int NUM_BINS = FFT_NUM_BINS,
    parameter int RD_LAT   = FFT_RD_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fft_done,
    output logic [ADDR_W-1:0]        fft_addr,
    input  logic signed [DATA_W-1:0] fft_re,
    input  logic signed [DATA_W-1:0] fft_im,
    fft_bin_reader_if.master         m_if,
    output logic                     busy,
    output logic                     overrun,
    output logic [ADDR_W-1:0]        peak_bin,
    output logic [2*DATA_W-1:0]      peak_mag,
    output logic                     peak_valid
);
    localparam int                  c_CNT_W    = $clog2(RD_LAT + 1);
    localparam logic [c_CNT_W-1:0]  c_RD_LAT   = c_CNT_W'(RD_LAT);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [ADDR_W-1:0]   c_LAST_BIN = ADDR_W'(NUM_BINS - 1);

    logic [STATE_W-1:0]       r_state;
    logic [STATE_W-1:0]       w_state_nxt;
    logic                     r_done_q;
    logic                     w_done_rise;
    logic                     w_start;
    logic                     w_load_addr;
    logic                     w_capture;
    logic                     w_mag_en;
    logic                     w_hs;
    logic [ADDR_W-1:0]        r_bin;
    logic [ADDR_W-1:0]        r_fft_addr;
    logic [c_CNT_W-1:0]       r_wait_cnt;
    logic signed [DATA_W-1:0] r_re;
    logic signed [DATA_W-1:0] r_im;
    logic                     r_m_valid;
    logic [ADDR_W-1:0]        r_m_bin;
    logic                     r_m_last;
    logic                     r_overrun;
    logic [2*DATA_W-1:0]      w_mag;

    assign w_done_rise = fft_done & ~r_done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_done_rise) w_state_nxt = S_ADDR;
            S_ADDR:  w_state_nxt = S_WAIT;
            S_WAIT:  if (r_wait_cnt == c_CNT_ONE) w_state_nxt = S_MAG;
            S_MAG:   w_state_nxt = S_OUT;
            S_OUT:   if (m_if.m_ready) w_state_nxt = r_m_last ? S_IDLE : S_ADDR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start     = (r_state == S_IDLE) && w_done_rise;
        w_load_addr = (r_state == S_ADDR);
        w_capture   = (r_state == S_WAIT) && (r_wait_cnt == c_CNT_ONE);
        w_mag_en    = (r_state == S_MAG);
        w_hs        = (r_state == S_OUT) && m_if.m_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done_q   <= 1'b0;
            r_overrun  <= 1'b0;
            r_bin      <= '0;
            r_fft_addr <= '0;
            r_wait_cnt <= '0;
            r_re       <= '0;
            r_im       <= '0;
            r_m_valid  <= 1'b0;
            r_m_bin    <= '0;
            r_m_last   <= 1'b0;
        end else begin
            r_done_q  <= fft_done;
            r_overrun <= w_done_rise && (r_state != S_IDLE);
            if (w_start) begin
                r_bin <= '0;
            end
            if (w_load_addr) begin
                r_fft_addr <= r_bin;
                r_wait_cnt <= c_RD_LAT;
            end
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (w_capture) begin
                r_re <= fft_re;
                r_im <= fft_im;
            end
            if (w_mag_en) begin
                r_m_valid <= 1'b1;
                r_m_bin   <= r_bin;
                r_m_last  <= (r_bin == c_LAST_BIN);
            end
            if (w_hs) begin
                r_m_valid <= 1'b0;
                if (!r_m_last) begin
                    r_bin <= r_bin + 1'b1;
                end
            end
        end
    end

    fft_bin_reader_mag_sq #(
        .DATA_W (DATA_W)
    ) u_mag_sq (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_mag_en),
        .i_re     (r_re),
        .i_im     (r_im),
        .o_mag_sq (w_mag)
    );

    assign fft_addr      = r_fft_addr;
    assign busy          = (r_state != S_IDLE);
    assign overrun       = r_overrun;
    assign m_if.m_valid  = r_m_valid;
    assign m_if.m_bin    = r_m_bin;
    assign m_if.m_mag_sq = w_mag;
    assign m_if.m_last   = r_m_last;

`ifdef FFT_READER_PEAK_EN
    logic [2*DATA_W-1:0] r_run_mag;
    logic [ADDR_W-1:0]   r_run_bin;
    logic [2*DATA_W-1:0] r_peak_mag;
    logic [ADDR_W-1:0]   r_peak_bin;
    logic                r_peak_valid;
    logic                w_better;

    // Strictly greater keeps the lowest bin on ties.
    assign w_better = (w_mag > r_run_mag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run_mag    <= '0;
            r_run_bin    <= '0;
            r_peak_mag   <= '0;
            r_peak_bin   <= '0;
            r_peak_valid <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            if (w_start) begin
                r_run_mag <= '0;
                r_run_bin <= '0;
            end else if (w_hs) begin
                if (w_better) begin
                    r_run_mag <= w_mag;
                    r_run_bin <= r_m_bin;
                end
                if (r_m_last) begin
                    r_peak_valid <= 1'b1;
                    r_peak_mag   <= w_better ? w_mag   : r_run_mag;
                    r_peak_bin   <= w_better ? r_m_bin : r_run_bin;
                end
            end
        end
    end

    assign peak_bin   = r_peak_bin;
    assign peak_mag   = r_peak_mag;
    assign peak_valid = r_peak_valid;
`else
    assign peak_bin   = '0;
    assign peak_mag   = '0;
    assign peak_valid = 1'b0;
`endif

endmodule
`default_nettype wire
